// File: rtl/rx_assemble.sv
// rx_assemble: collects NBYTES UART bytes (first byte at the MSB end) into one
// block and pushes it downstream with a single-cycle write strobe. Bytes that
// arrive while a finished block waits on a full buffer are dropped and flagged.
// Optional feature macro: RX_TIMEOUT_EN (idle timeout that discards a partial
// block and pulses frame_err). With the macro undefined, frame_err stays 0.
module rx_assemble #(
   parameter int NBYTES         = 16,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          rx_data,
   input  logic                rx_done,
   input  logic                buffer_full,
   output logic                buffer_write,
   output logic [8*NBYTES-1:0] d_out,
   output logic                overrun,
   output logic                frame_err
);

   localparam int BW = 8*NBYTES;
   localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic {
      COLLECT = 1'b0,
      PUSH    = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] ctr_q, ctr_d;
   logic [BW-1:0] sr_q, sr_d;
   logic [BW-1:0] dout_q, dout_d;
   logic          ovr_q, ovr_d;
   logic          ferr_q, ferr_d;
   logic          push_wr;

`ifdef RX_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
   logic [IW-1:0] idle_q, idle_d;
`else
   // Timeout length is meaningless without the idle counter.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   // Next-state, datapath updates and the combinational write strobe.
   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      sr_d    = sr_q;
      dout_d  = dout_q;
      ovr_d   = 1'b0;
      ferr_d  = 1'b0;
      push_wr = 1'b0;
`ifdef RX_TIMEOUT_EN
      idle_d  = idle_q;
`endif
      case (state_q)
         COLLECT: begin
            if (rx_done) begin
               sr_d = BW'({sr_q, rx_data});
               if (ctr_q == CW'(NBYTES - 1)) begin
                  ctr_d   = '0;
                  state_d = PUSH;
               end else begin
                  ctr_d = ctr_q + 1'b1;
               end
`ifdef RX_TIMEOUT_EN
               idle_d = '0;
`endif
            end
`ifdef RX_TIMEOUT_EN
            // Idle cycles only count while a partial block is held.
            else if (ctr_q != '0) begin
               if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
                  idle_d = '0;
                  ctr_d  = '0;
                  sr_d   = '0;
                  ferr_d = 1'b1;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
`endif
         end
         PUSH: begin
            // Any byte seen here, including in the write cycle itself, is lost.
            ovr_d = rx_done;
            if (!buffer_full) begin
               push_wr = 1'b1;
               dout_d  = sr_q;
               state_d = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= COLLECT;
      else       state_q <= state_d;
   end

   // Byte counter, shift register, held output block and flag pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctr_q  <= '0;
         sr_q   <= '0;
         dout_q <= '0;
         ovr_q  <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         ctr_q  <= ctr_d;
         sr_q   <= sr_d;
         dout_q <= dout_d;
         ovr_q  <= ovr_d;
         ferr_q <= ferr_d;
      end
   end

`ifdef RX_TIMEOUT_EN
   // Idle counter between bytes of a partial block.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) idle_q <= '0;
      else       idle_q <= idle_d;
   end
`endif

   // The strobe is combinational so the block is visible in the write cycle;
   // d_out bypasses the held copy in that cycle and holds it afterwards.
   assign buffer_write = push_wr;
   assign d_out        = push_wr ? sr_q : dout_q;
   assign overrun      = ovr_q;
`ifdef RX_TIMEOUT_EN
   assign frame_err    = ferr_q;
`else
   assign frame_err    = 1'b0;
   logic unused_ferr;
   assign unused_ferr  = ferr_q;
`endif

endmodule

// File: tb/tb_rx_assemble.sv
// Testbench for rx_assemble: directed byte sequences, a block-level reference
// model checked every cycle, and literal expectations per scenario.
module tb_rx_assemble;

   localparam int NB = 16;
   localparam int BW = 8*NB;
   localparam int TO = 100;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_done = 1'b0;
   logic          buffer_full = 1'b0;
   logic          buffer_write;
   logic [BW-1:0] d_out;
   logic          overrun;
   logic          frame_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   rx_assemble #(.NBYTES(NB), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
      .buffer_full(buffer_full), .buffer_write(buffer_write), .d_out(d_out),
      .overrun(overrun), .frame_err(frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (block level) ----------------
   logic [7:0]    m_bytes[$];
   bit            m_pend = 1'b0;
   logic [BW-1:0] m_blk  = '0;
   logic [BW-1:0] m_dout = '0;
   bit            m_ovr  = 1'b0;
   bit            m_ferr = 1'b0;
   int            m_idle = 0;

   logic [BW-1:0] wr_dat[$];
   int            wr_cyc[$];
   int            n_ovr  = 0;
   int            n_ferr = 0;

   always @(negedge clk) begin : cmp
      bit            exp_wr, nxt_ovr, nxt_ferr;
      logic [BW-1:0] exp_do;
      if (reset) begin
         m_bytes.delete();
         m_pend = 1'b0; m_blk = '0; m_dout = '0;
         m_ovr = 1'b0; m_ferr = 1'b0; m_idle = 0;
      end
      exp_wr = m_pend && !buffer_full;
      exp_do = exp_wr ? m_blk : m_dout;
      chk("buffer_write", BW'(buffer_write), BW'(exp_wr));
      chk("d_out", d_out, exp_do);
      chk("overrun", BW'(overrun), BW'(m_ovr));
      chk("frame_err", BW'(frame_err), BW'(m_ferr));
      if (buffer_write === 1'b1) begin
         wr_dat.push_back(d_out);
         wr_cyc.push_back(cyc);
      end
      if (overrun === 1'b1)   n_ovr++;
      if (frame_err === 1'b1) n_ferr++;
      if (!reset) begin
         nxt_ovr  = m_pend && rx_done;
         nxt_ferr = 1'b0;
         if (m_pend) begin
            if (!buffer_full) begin
               m_dout = m_blk;
               m_pend = 1'b0;
            end
         end else if (rx_done) begin
            m_bytes.push_back(rx_data);
            m_idle = 0;
            if (m_bytes.size() == NB) begin
               m_blk = '0;
               foreach (m_bytes[i]) m_blk[BW-1-8*i -: 8] = m_bytes[i];
               m_bytes.delete();
               m_pend = 1'b1;
            end
         end
`ifdef RX_TIMEOUT_EN
         else if (m_bytes.size() > 0) begin
            m_idle++;
            if (m_idle == TO) begin
               m_bytes.delete();
               m_idle   = 0;
               nxt_ferr = 1'b1;
            end
         end
`endif
         m_ovr  = nxt_ovr;
         m_ferr = nxt_ferr;
      end
   end

   // ---------------- stimulus helpers ----------------
   int last_rx = 0;
   int drop_c  = 0;

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      last_rx = cyc;
      @(posedge clk);
      #1;
      rx_done = 1'b0;
   endtask

   task automatic clear_log();
      wr_dat.delete();
      wr_cyc.delete();
      n_ovr  = 0;
      n_ferr = 0;
   endtask

   function automatic logic [BW-1:0] wd(int k);
      if (k < wr_dat.size()) return wr_dat[k];
      return 'x;
   endfunction

   function automatic int wc(int k);
      if (k < wr_cyc.size()) return wr_cyc[k];
      return -1;
   endfunction

   initial begin
      tick(3);
      chk("reset d_out", d_out, '0);
      chk("reset buffer_write", BW'(buffer_write), '0);
      chk("reset overrun", BW'(overrun), '0);
      reset = 1'b0;
      tick(2);

      // Test 1: 0x00..0x0F, buffer free.
      clear_log();
      for (int i = 0; i < NB; i++) begin
         send(8'(i));
         tick(1);
      end
      tick(5);
      chk("t1 writes", BW'(wr_dat.size()), BW'(1));
      chk("t1 data", wd(0), 128'h000102030405060708090A0B0C0D0E0F);
      chk("t1 latency", BW'(wc(0)), BW'(last_rx + 1));

      // Test 2: buffer full while the block completes, then 20 cycles more.
      clear_log();
      buffer_full = 1'b1;
      for (int i = 0; i < NB; i++) begin
         send(8'(8'h10 + i));
         tick(1);
      end
      tick(20);
      buffer_full = 1'b0;
      drop_c = cyc;
      tick(5);
      chk("t2 writes", BW'(wr_dat.size()), BW'(1));
      chk("t2 data", wd(0), 128'h101112131415161718191A1B1C1D1E1F);
      chk("t2 write cycle", BW'(wc(0)), BW'(drop_c));

      // Test 3: two bytes arrive while the block waits on a full buffer.
      clear_log();
      buffer_full = 1'b1;
      for (int i = 0; i < NB; i++) begin
         send(8'(8'h20 + i));
         tick(1);
      end
      tick(3);
      send(8'hEE);
      tick(2);
      send(8'hEF);
      tick(5);
      buffer_full = 1'b0;
      tick(2);
      for (int i = 0; i < NB; i++) begin
         send(8'(8'h30 + i));
         tick(1);
      end
      tick(5);
      chk("t3 overruns", BW'(n_ovr), BW'(2));
      chk("t3 writes", BW'(wr_dat.size()), BW'(2));
      chk("t3 data0", wd(0), 128'h202122232425262728292A2B2C2D2E2F);
      chk("t3 data1", wd(1), 128'h303132333435363738393A3B3C3D3E3F);

      // Test 4: reset after 7 bytes, then a fresh block.
      for (int i = 0; i < 7; i++) begin
         send(8'(8'h70 + i));
         tick(1);
      end
      reset = 1'b1;
      #1;
      chk("t4 d_out in reset", d_out, '0);
      chk("t4 write in reset", BW'(buffer_write), '0);
      tick(2);
      reset = 1'b0;
      clear_log();
      for (int i = 0; i < NB; i++) begin
         send(8'(8'hAA + i));
         tick(1);
      end
      tick(5);
      chk("t4 writes", BW'(wr_dat.size()), BW'(1));
      chk("t4 data", wd(0), 128'hAAABACADAEAFB0B1B2B3B4B5B6B7B8B9);

      // Test 5: 33 back-to-back bytes; the 17th lands in the write cycle.
      clear_log();
      for (int i = 0; i < 2*NB + 1; i++) send(8'(8'h40 + i));
      tick(5);
      chk("t5 writes", BW'(wr_dat.size()), BW'(2));
      chk("t5 data0", wd(0), 128'h404142434445464748494A4B4C4D4E4F);
      chk("t5 data1", wd(1), 128'h5152535455565758595A5B5C5D5E5F60);
      chk("t5 spacing", BW'(wc(1) - wc(0)), BW'(17));
      chk("t5 overruns", BW'(n_ovr), BW'(1));

`ifdef RX_TIMEOUT_EN
      // Test 6: partial block of 5 bytes times out.
      clear_log();
      for (int i = 0; i < 5; i++) begin
         send(8'(8'h90 + i));
         tick(1);
      end
      tick(TO + 10);
      chk("t6 frame_err pulses", BW'(n_ferr), BW'(1));
      chk("t6 no write", BW'(wr_dat.size()), BW'(0));
      for (int i = 0; i < NB; i++) begin
         send(8'(8'hC0 + i));
         tick(1);
      end
      tick(5);
      chk("t6 writes", BW'(wr_dat.size()), BW'(1));
      chk("t6 data", wd(0), 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
`endif

      tick(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
